crc16_serial_checker: RTL and testbench
=======================================

# crc16_serial_checker

Receive-side companion to the serial CRC-16 generator: consumes a serial frame of DATA_BITS payload bits followed by 16 CRC bits, recomputes CRC-16 (CCITT polynomial, MSB first) over the payload, and flags match or mismatch. It sits directly downstream of the serial CRC generator and its bit source, on the same clock. It reports a one-cycle verdict per frame and keeps a saturating error count.

## Interface
- DATA_BITS, 32, payload bits per frame (≥1, ≤64)
- POLY, 16'h1021, CRC polynomial (x^16 implicit)
- INIT, 16'h0000, CRC register value at frame start
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- frame_start  in  1  starts (or restarts) a frame; the bit_in on this cycle is not consumed
- bit_valid  in  1  bit_in is a valid serial bit this cycle
- bit_in  in  1  serial bit: payload MSB first, then received CRC MSB first
- busy  out  1  frame in progress (DATA or CHECK)
- done  out  1  one-cycle verdict strobe
- crc_ok  out  1  valid with done; calc_crc == rx_crc
- crc_err  out  1  valid with done; mismatch
- calc_crc  out  16  CRC computed over the last payload; held until the next frame's payload completes
- rx_crc  out  16  received CRC of last frame; held likewise
- err_count  out  8  mismatching frames since reset; saturates at 255

## Operation
- States: IDLE, DATA, CHECK.
- IDLE: frame_start → DATA; crc ← INIT, bit_cnt ← 0. bit_valid is ignored.
- DATA: each bit_valid cycle: fb = bit_in ^ crc[15]; crc ← {crc[14:0],1'b0} ^ (fb ? POLY : 0); bit_cnt++. On the DATA_BITS-th bit: calc_crc ← updated crc, bit_cnt ← 0, go to CHECK.
- CHECK: each bit_valid cycle: rx_shift ← {rx_shift[14:0], bit_in}; bit_cnt++. On the 16th bit: rx_crc ← final shift value, compare with calc_crc, go to IDLE, and raise done next cycle.
- bit_cnt: 7 bits, no wrap inside a frame. It resets on every transition.
- frame_start in DATA or CHECK: the current frame is aborted. No done, err_count unchanged. Restart as from IDLE in the same cycle.
- frame_start and the final CRC bit in the same cycle: the frame is aborted (frame_start wins), and no verdict is given.
- err_count increments on a crc_err strobe, and holds at 8'hFF.

## Timing
- Reset values: state IDLE, busy 0, done 0, crc_ok 0, crc_err 0, calc_crc 16'h0000, rx_crc 16'h0000, err_count 0.
- rst mid-frame: the frame is discarded immediately and all outputs return to their reset values on the next edge.
- done, crc_ok and crc_err are registered. They are high exactly one cycle, the cycle after the 16th CRC bit is sampled. crc_ok and crc_err are 0 whenever done is 0.
- busy is high from the cycle after frame_start through the cycle the last CRC bit is sampled. It is low in the done cycle.
- Gaps (bit_valid=0) are allowed anywhere in a frame and stall the state.
- Minimum frame: 1 + DATA_BITS + 16 cycles to the last bit, plus 1 cycle to done. A new frame_start may coincide with done.
- err_count updates in the same cycle that done is asserted.

## Structure
- Shared package crc16_pkg: CRC16_POLY_CCITT, CRC16_INIT_ZERO, state enum {IDLE, DATA, CHECK}, and function crc16_step(crc, bit, poly) returning the next CRC. The same function is used by the generator model in the bench.
- One natural sub-module: crc16_serial_core (crc register, clear/enable/bit inputs, POLY/INIT parameters). The top holds the FSM, bit counter, rx shift register, compare and error counter.

## Test plan
- Payload 32'h0000_0000, CRC bits 16'h0000 → done one cycle after the last bit, crc_ok=1, calc_crc=16'h0000, err_count=0.
- Payload 32'h0000_0001, CRC bits 16'h1021 → crc_ok=1, calc_crc=16'h1021. Payload 32'h0000_0002, CRC bits 16'h2042 → crc_ok=1.
- Payload 32'h0000_0001, CRC bits 16'h1020 → crc_err=1, rx_crc=16'h1020, err_count=1. Repeat 300 bad frames → err_count stays at 255.
- Good frame with random bit_valid gaps (about 50% duty) → same verdict and calc_crc as the gap-free run. busy stays high throughout.
- frame_start reasserted after 20 payload bits, then a full good frame → exactly one done, crc_ok=1, err_count unchanged.
- rst asserted for one cycle during CHECK → next cycle all outputs at reset values, no done. The following good frame passes.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions for the serial CRC generator/checker pair.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY_CCITT = 16'h1021;
  localparam logic [15:0] CRC16_INIT_ZERO  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // One MSB-first shift of the CRC register with the next serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        din,
                                             input logic [15:0] poly);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial_core.sv
// Serial CRC-16 register: cleared to INIT, advanced one bit per enabled cycle.
module crc16_serial_core
  import crc16_pkg::*;
#(
  parameter logic [15:0] POLY = CRC16_POLY_CCITT,
  parameter logic [15:0] INIT = CRC16_INIT_ZERO
) (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic        i_bit,
  output logic [15:0] o_crc_next
);

  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  assign w_crc_next = crc16_step(r_crc, i_bit, POLY);
  assign o_crc_next = w_crc_next;

  // Clear has priority so a restart in the same cycle as a bit discards that bit.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_crc <= INIT;
    end else if (i_enable) begin
      r_crc <= w_crc_next;
    end
  end

endmodule

// File: rtl/crc16_serial_checker.sv
// Receive-side serial CRC-16 checker: recomputes the payload CRC, compares it
// with the trailing received CRC, and strobes a one-cycle verdict per frame.
module crc16_serial_checker
  import crc16_pkg::*;
#(
  parameter int          DATA_BITS = 32,
  parameter logic [15:0] POLY      = CRC16_POLY_CCITT,
  parameter logic [15:0] INIT      = CRC16_INIT_ZERO
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_start,
  input  logic        i_bit_valid,
  input  logic        i_bit_in,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_crc_ok,
  output logic        o_crc_err,
  output logic [15:0] o_calc_crc,
  output logic [15:0] o_rx_crc,
  output logic [7:0]  o_err_count
);

  localparam logic [6:0] LAST_DATA  = 7'(DATA_BITS - 1);
  localparam logic [6:0] LAST_CHECK = 7'd15;

  state_e      r_state;
  state_e      w_next_state;
  logic [6:0]  r_bit_cnt;
  logic [15:0] r_rx_shift;
  logic [15:0] r_calc_crc;
  logic [15:0] r_rx_crc;
  logic [7:0]  r_err_count;
  logic        r_done;
  logic        r_crc_ok;
  logic        r_crc_err;
  logic [15:0] w_crc_next;
  logic [15:0] w_rx_final;
  logic        w_data_bit;
  logic        w_data_last;
  logic        w_chk_bit;
  logic        w_chk_last;
  logic        w_mismatch;

  crc16_serial_core #(
    .POLY(POLY),
    .INIT(INIT)
  ) u_core (
    .i_clk      (i_clk),
    .i_clear    (i_rst | i_frame_start),
    .i_enable   (w_data_bit),
    .i_bit      (i_bit_in),
    .o_crc_next (w_crc_next)
  );

  // frame_start pre-empts any bit in the same cycle, including the last CRC bit.
  always_comb begin
    w_data_bit  = (r_state == DATA)  && i_bit_valid && !i_frame_start;
    w_chk_bit   = (r_state == CHECK) && i_bit_valid && !i_frame_start;
    w_data_last = w_data_bit && (r_bit_cnt == LAST_DATA);
    w_chk_last  = w_chk_bit  && (r_bit_cnt == LAST_CHECK);
    w_rx_final  = {r_rx_shift[14:0], i_bit_in};
    w_mismatch  = (w_rx_final != r_calc_crc);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_frame_start) w_next_state = DATA;
        else               w_next_state = IDLE;
      end
      DATA: begin
        if (i_frame_start)    w_next_state = DATA;
        else if (w_data_last) w_next_state = CHECK;
        else                  w_next_state = DATA;
      end
      CHECK: begin
        if (i_frame_start)   w_next_state = DATA;
        else if (w_chk_last) w_next_state = IDLE;
        else                 w_next_state = CHECK;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != IDLE);
    o_done      = r_done;
    o_crc_ok    = r_crc_ok;
    o_crc_err   = r_crc_err;
    o_calc_crc  = r_calc_crc;
    o_rx_crc    = r_rx_crc;
    o_err_count = r_err_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt   <= 7'd0;
      r_rx_shift  <= 16'h0000;
      r_calc_crc  <= 16'h0000;
      r_rx_crc    <= 16'h0000;
      r_err_count <= 8'd0;
      r_done      <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_crc_err   <= 1'b0;
    end else begin
      r_done    <= w_chk_last;
      r_crc_ok  <= w_chk_last && !w_mismatch;
      r_crc_err <= w_chk_last && w_mismatch;

      if (i_frame_start || w_data_last || w_chk_last) begin
        r_bit_cnt <= 7'd0;
      end else if (w_data_bit || w_chk_bit) begin
        r_bit_cnt <= r_bit_cnt + 7'd1;
      end

      if (i_frame_start) begin
        r_rx_shift <= 16'h0000;
      end else if (w_chk_bit) begin
        r_rx_shift <= w_rx_final;
      end

      if (w_data_last) begin
        r_calc_crc <= w_crc_next;
      end

      if (w_chk_last) begin
        r_rx_crc <= w_rx_final;
      end

      // Saturating error count, updated on the same edge that raises done.
      if (w_chk_last && w_mismatch && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Directed/randomized bench for crc16_serial_checker against a polynomial-division model.
module tb_crc16_serial_checker;

  localparam int DB = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs  = 1'b0;
  logic        bv  = 1'b0;
  logic        bi  = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        o_crc_ok;
  logic        o_crc_err;
  logic [15:0] o_calc_crc;
  logic [15:0] o_rx_crc;
  logic [7:0]  o_err_count;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int exp_err = 0;

  crc16_serial_checker #(.DATA_BITS(DB)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (fs),
    .i_bit_valid   (bv),
    .i_bit_in      (bi),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_crc_ok      (o_crc_ok),
    .o_crc_err     (o_crc_err),
    .o_calc_crc    (o_calc_crc),
    .o_rx_crc      (o_rx_crc),
    .o_err_count   (o_err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_done) n_done++;

  // Reference: remainder of payload * x^16 divided by x^16 + POLY (INIT = 0).
  function automatic logic [15:0] ref_crc(input logic [63:0] payload);
    logic [16:0] rem;
    logic        b;
    rem = 17'h0;
    for (int i = DB + 15; i >= 0; i--) begin
      if (i >= 16) b = payload[i - 16];
      else         b = 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h1_1021;
    end
    return rem[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge; return after the next falling edge.
  task automatic drive(input logic r, input logic f, input logic v, input logic b);
    rst = r; fs = f; bv = v; bi = b;
    @(negedge clk);
  endtask

  task automatic gaps(input bit gappy);
    int n;
    n = 0;
    if (gappy) begin
      while (($urandom_range(0, 1) == 1) && (n < 6)) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_gap", 32'(o_busy), 32'd1);
        n++;
      end
    end
  endtask

  task automatic run_frame(input logic [63:0] payload, input logic [15:0] crc_tx,
                           input bit gappy, input bit start);
    logic [15:0] exp_crc;
    bit          ok;
    exp_crc = ref_crc(payload);
    ok = (crc_tx == exp_crc);
    if (start) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk("busy_start", 32'(o_busy), 32'd1);
    end
    for (int i = DB - 1; i >= 0; i--) begin
      gaps(gappy);
      drive(1'b0, 1'b0, 1'b1, payload[i]);
      chk("busy_data", 32'(o_busy), 32'd1);
    end
    for (int i = 15; i >= 0; i--) begin
      gaps(gappy);
      drive(1'b0, 1'b0, 1'b1, crc_tx[i]);
      if (i > 0) chk("busy_crc", 32'(o_busy), 32'd1);
    end
    if (!ok && exp_err < 255) exp_err++;
    chk("done",      32'(o_done),      32'd1);
    chk("crc_ok",    32'(o_crc_ok),    32'(ok));
    chk("crc_err",   32'(o_crc_err),   32'(!ok));
    chk("calc_crc",  32'(o_calc_crc),  32'(exp_crc));
    chk("rx_crc",    32'(o_rx_crc),    32'(crc_tx));
    chk("err_count", 32'(o_err_count), 32'(exp_err));
    chk("busy_done", 32'(o_busy),      32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_drop", 32'(o_done),    32'd0);
    chk("ok_drop",   32'(o_crc_ok),  32'd0);
    chk("err_drop",  32'(o_crc_err), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy",  32'(o_busy),      32'd0);
    chk("rst_done",  32'(o_done),      32'd0);
    chk("rst_ok",    32'(o_crc_ok),    32'd0);
    chk("rst_err",   32'(o_crc_err),   32'd0);
    chk("rst_calc",  32'(o_calc_crc),  32'd0);
    chk("rst_rx",    32'(o_rx_crc),    32'd0);
    chk("rst_count", 32'(o_err_count), 32'd0);
  endtask

  initial begin
    logic [63:0] p;
    logic [15:0] c;
    int          d0;

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk_reset_vals();

    // Directed known-answer frames.
    run_frame(64'h0, 16'h0000, 1'b0, 1'b1);
    run_frame(64'h1, 16'h1021, 1'b0, 1'b1);
    run_frame(64'h2, 16'h2042, 1'b0, 1'b1);
    run_frame(64'h1, 16'h1020, 1'b0, 1'b1);

    // Random good and bad frames, some with gaps.
    for (int k = 0; k < 12; k++) begin
      p = 64'($urandom);
      c = ref_crc(p);
      if (k % 3 == 2) c = c ^ 16'($urandom_range(1, 65535));
      run_frame(p, c, (k % 2) == 1, 1'b1);
    end

    // Gap-free vs gappy on the same payload.
    p = 64'($urandom);
    run_frame(p, ref_crc(p), 1'b0, 1'b1);
    run_frame(p, ref_crc(p), 1'b1, 1'b1);

    // Saturate the error counter.
    for (int k = 0; k < 300; k++) begin
      p = 64'($urandom);
      run_frame(p, ref_crc(p) ^ 16'h0001, 1'b0, 1'b1);
    end
    chk("err_sat", 32'(o_err_count), 32'd255);

    // Abort after 20 payload bits, then a full good frame.
    d0 = n_done;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    p = 64'($urandom);
    run_frame(p, ref_crc(p), 1'b0, 1'b1);
    chk("abort_one_done", 32'(n_done - d0), 32'd1);

    // frame_start on the final CRC bit: no verdict, new frame begins there.
    d0 = n_done;
    p = 64'($urandom);
    c = ref_crc(p);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = DB - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, p[i]);
    for (int i = 15; i >= 1; i--) drive(1'b0, 1'b0, 1'b1, c[i]);
    drive(1'b0, 1'b1, 1'b1, c[0]);
    chk("fs_last_no_done", 32'(o_done), 32'd0);
    chk("fs_last_busy", 32'(o_busy), 32'd1);
    p = 64'($urandom);
    run_frame(p, ref_crc(p), 1'b0, 1'b0);
    chk("fs_last_one_done", 32'(n_done - d0), 32'd1);

    // Reset during CHECK.
    d0 = n_done;
    p = 64'($urandom);
    c = ref_crc(p);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = DB - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b1, p[i]);
    for (int i = 15; i >= 11; i--) drive(1'b0, 1'b0, 1'b1, c[i]);
    drive(1'b1, 1'b0, 1'b1, c[10]);
    exp_err = 0;
    chk_reset_vals();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_no_done", 32'(n_done - d0), 32'd0);
    p = 64'($urandom);
    run_frame(p, ref_crc(p), 1'b0, 1'b1);
    run_frame(p, ref_crc(p) ^ 16'h8000, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
